write_mem_burst_ctrl: RTL and testbench
=======================================

WRITE_MEM_BURST_CTRL -- requirements
Module: write_mem_burst_ctrl

Interface
REQ-001 SHALL have parameter ADD_SIZE, default 12, memory address width.
REQ-002 SHALL have parameter DATA_SIZE, default 108, data word width.
REQ-003 SHALL have parameter NUM_CH, default 2, number of requesting channels (1..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-005 SHALL have parameter LEN_W, default 4, burst-length field width (length = field+1 beats).
REQ-006 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-007 SHALL provide ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- ch_cmd_valid  in  NUM_CH  per-channel burst request
- ch_cmd_addr  in  NUM_CH*ADD_SIZE  per-channel start address, channel i at bits [i*ADD_SIZE +: ADD_SIZE]
- ch_cmd_len  in  NUM_CH*LEN_W  per-channel beats minus one
- ch_cmd_ready  out  NUM_CH  one-cycle command-accept pulse
- ch_data_valid  in  NUM_CH  per-channel data beat valid
- ch_data  in  NUM_CH*DATA_SIZE  per-channel data beat
- ch_data_ready  out  NUM_CH  per-channel data accept
- mem_ready  in  1  memory accepts write this cycle
- write_en_out  out  1  memory write strobe
- address_out  out  ADD_SIZE  memory write address
- dataOut  out  DATA_SIZE  memory write data
- busy  out  1  high whenever state is not IDLE
- done  out  NUM_CH  one-cycle pulse when a channel's burst is fully written

Function
REQ-008 SHALL implement states IDLE, BURST, DRAIN.
REQ-009 In IDLE with any ch_cmd_valid set, SHALL grant one channel round-robin, searching from (last grant+1) mod NUM_CH; channel 0 has priority after reset.
REQ-010 On grant SHALL pulse ch_cmd_ready[g] for exactly that cycle, latch address and length, enter BURST next cycle.
REQ-011 In BURST, ch_data_ready[g] SHALL equal !fifo_full (registered full flag); all other ch_data_ready bits SHALL be 0.
REQ-012 Each accepted beat (valid && ready) SHALL be pushed with the current address; address SHALL increment by 1 per beat, wrapping modulo 2^ADD_SIZE (all-ones -> 0).
REQ-013 After the (len+1)th accepted beat SHALL enter DRAIN; ch_data_valid outside BURST or on non-granted channels SHALL be ignored.
REQ-014 In DRAIN, once FIFO is empty and no write is pending, SHALL pulse done[g] for one cycle and return to IDLE; a new grant SHALL occur no earlier than the cycle after done.
REQ-015 write_en_out SHALL be high whenever FIFO is non-empty; address_out/dataOut SHALL present the FIFO head and stay stable while mem_ready is low.
REQ-016 FIFO SHALL pop when write_en_out && mem_ready; push and pop in the same cycle SHALL both take effect.
REQ-017 A beat accepted in cycle N SHALL appear on write_en_out no earlier than cycle N+1 (with empty FIFO, exactly N+1).
REQ-018 When FIFO is full and a pop occurs, ready SHALL remain low that cycle (no bypass); no beat SHALL ever be lost or duplicated.
REQ-019 When write_en_out is low, address_out and dataOut SHALL hold their last values.

Reset
REQ-020 When rst is low at a clock edge, all outputs SHALL be 0, state IDLE, FIFO flushed, round-robin pointer reset so channel 0 has priority next.
REQ-021 Reset mid-burst SHALL discard buffered beats without issuing further writes; done SHALL NOT pulse.

Structure
REQ-022 Shared package write_mem_pkg SHALL hold the state enum and the FIFO pointer-width helper.
REQ-023 Buffer SHALL be sub-module wm_fifo (synchronous FIFO, parameters DEPTH and WIDTH=ADD_SIZE+DATA_SIZE).

Verification
REQ-024 Single burst: ch0 cmd addr 0x010 len 3, beats 0x115,0x117,0x120,0x121, mem_ready=1 -> writes at 0x010..0x013 in order, done[0] one pulse.
REQ-025 Wrap: addr 0xFFE len 3 -> address_out 0xFFE,0xFFF,0x000,0x001.
REQ-026 Backpressure: mem_ready=0 for 10 cycles during 8-beat burst -> ch_data_ready drops after FIFO_DEPTH beats, address/data held stable, all 8 written once.
REQ-027 Arbitration: ch0 and ch1 request together twice -> grants ch0, ch1, ch0, ch1 (NUM_CH=2).
REQ-028 Reset mid-burst: rst low after beat 2 of 4 -> outputs 0 next edge, no further writes, no done; subsequent ch1 request granted normally.

Source files
------------

// File: rtl/write_mem_pkg.sv
// Shared types for the burst write controller: controller state encoding and
// the FIFO pointer-width helper.
package write_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } wm_state_e;

    function automatic int f_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wm_fifo.sv
// Synchronous write buffer with a registered head: o_head always shows the
// oldest entry and keeps its last value once the buffer drains.
module wm_fifo
    import write_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_empty,
    output logic             o_full,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = f_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] w_head_next;
    logic             w_push;
    logic             w_pop;

    assign w_push       = i_push && !r_full;
    assign w_pop        = i_pop && !r_empty;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

    // The head register is loaded with whatever will be oldest after this edge.
    always_comb begin
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_head_next  = r_head;
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end else if (w_push) begin
                w_head_next = i_wdata;
            end
        end else if (r_empty && w_push) begin
            w_head_next = i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_head  <= w_head_next;
        end
    end

    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_head  = r_head;

endmodule

// File: rtl/write_mem_burst_ctrl.sv
// Multi-channel burst write controller: round-robin command arbitration,
// per-beat address generation and a buffered memory write port.
module write_mem_burst_ctrl
    import write_mem_pkg::*;
#(
    parameter int ADD_SIZE   = 12,
    parameter int DATA_SIZE  = 108,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_cmd_valid,
    input  logic [NUM_CH*ADD_SIZE-1:0]  ch_cmd_addr,
    input  logic [NUM_CH*LEN_W-1:0]     ch_cmd_len,
    output logic [NUM_CH-1:0]           ch_cmd_ready,
    input  logic [NUM_CH-1:0]           ch_data_valid,
    input  logic [NUM_CH*DATA_SIZE-1:0] ch_data,
    output logic [NUM_CH-1:0]           ch_data_ready,
    input  logic                        mem_ready,
    output logic                        write_en_out,
    output logic [ADD_SIZE-1:0]         address_out,
    output logic [DATA_SIZE-1:0]        dataOut,
    output logic                        busy,
    output logic [NUM_CH-1:0]           done
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EW = ADD_SIZE + DATA_SIZE;

    wm_state_e          r_state;
    wm_state_e          w_state_next;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      w_grant_idx;
    logic [GW-1:0]      w_idx;
    logic               w_found;
    logic               w_grant_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [EW-1:0]      w_head;
    logic [ADD_SIZE-1:0] r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat_cnt;

    logic [ADD_SIZE-1:0]  w_cmd_addr [NUM_CH];
    logic [LEN_W-1:0]     w_cmd_len  [NUM_CH];
    logic [DATA_SIZE-1:0] w_data     [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_cmd_addr[gi] = ch_cmd_addr[gi*ADD_SIZE +: ADD_SIZE];
            assign w_cmd_len[gi]  = ch_cmd_len[gi*LEN_W +: LEN_W];
            assign w_data[gi]     = ch_data[gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    // r_grant doubles as the round-robin pointer; search starts one past it.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = GW'((int'(r_grant) + k) % NUM_CH);
            if (!w_found && ch_cmd_valid[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        ch_cmd_ready  = '0;
        ch_data_ready = '0;
        done          = '0;
        w_grant_fire  = 1'b0;
        w_push        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst && w_found) begin
                    ch_cmd_ready[w_grant_idx] = 1'b1;
                    w_grant_fire              = 1'b1;
                    w_state_next              = ST_BURST;
                end
            end
            ST_BURST: begin
                ch_data_ready[r_grant] = !w_fifo_full;
                w_push = ch_data_valid[r_grant] && !w_fifo_full;
                if (w_push && (r_beat_cnt == r_len)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_fifo_empty) begin
                    done[r_grant] = 1'b1;
                    w_state_next  = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= GW'(NUM_CH - 1);
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_fire) begin
                r_grant    <= w_grant_idx;
                r_addr     <= w_cmd_addr[w_grant_idx];
                r_len      <= w_cmd_len[w_grant_idx];
                r_beat_cnt <= '0;
            end else if (w_push) begin
                r_addr     <= r_addr + ADD_SIZE'(1);
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
        end
    end

    assign w_pop = write_en_out && mem_ready;

    wm_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({r_addr, w_data[r_grant]}),
        .i_pop   (w_pop),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_head  (w_head)
    );

    assign write_en_out = !w_fifo_empty;
    assign address_out  = w_head[EW-1 -: ADD_SIZE];
    assign dataOut      = w_head[DATA_SIZE-1:0];
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_write_mem_burst_ctrl.sv
// Directed and randomized bench for write_mem_burst_ctrl with a cycle-level
// reference model built from the arbitration, buffering and write rules.
module tb_write_mem_burst_ctrl;
    localparam int AW    = 12;
    localparam int DW    = 108;
    localparam int NC    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     ch_cmd_valid;
    logic [NC*AW-1:0]  ch_cmd_addr;
    logic [NC*LW-1:0]  ch_cmd_len;
    logic [NC-1:0]     ch_cmd_ready;
    logic [NC-1:0]     ch_data_valid;
    logic [NC*DW-1:0]  ch_data;
    logic [NC-1:0]     ch_data_ready;
    logic              mem_ready;
    logic              write_en_out;
    logic [AW-1:0]     address_out;
    logic [DW-1:0]     dataOut;
    logic              busy;
    logic [NC-1:0]     done;

    write_mem_burst_ctrl #(
        .ADD_SIZE(AW), .DATA_SIZE(DW), .NUM_CH(NC), .FIFO_DEPTH(DEPTH), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_cmd_valid(ch_cmd_valid), .ch_cmd_addr(ch_cmd_addr), .ch_cmd_len(ch_cmd_len),
        .ch_cmd_ready(ch_cmd_ready), .ch_data_valid(ch_data_valid), .ch_data(ch_data),
        .ch_data_ready(ch_data_ready), .mem_ready(mem_ready), .write_en_out(write_en_out),
        .address_out(address_out), .dataOut(dataOut), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              phase;      // 0 idle, 1 burst, 2 drain
    int              g_ch, b_len, b_acc, rr_last;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   cur_beats [16];
    bit              req_pend  [NC];
    logic [AW-1:0]   req_addr  [NC];
    int              req_len   [NC];
    logic [DW-1:0]   req_beats [NC][16];
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] last_head;
    int              done_cnt  [NC];
    int              grant_log[$];

    // Stimulus knobs
    bit rst_drv;
    int mr_mode;   // 0 always ready, 1 random, 2 never ready
    bit dv_rand;
    bit noise_en;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic bit model_idle();
        bit any;
        any = 1'b0;
        for (int c = 0; c < NC; c++) any |= req_pend[c];
        return (phase == 0) && (exp_q.size() == 0) && !any;
    endfunction

    task automatic submit(input int c, input logic [AW-1:0] a, input int len);
        req_pend[c] = 1'b1;
        req_addr[c] = a;
        req_len[c]  = len;
        for (int i = 0; i < 16; i++) req_beats[c][i] = rnd_data();
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
        rst = rst_drv;
        case (mr_mode)
            0:       mem_ready = 1'b1;
            2:       mem_ready = 1'b0;
            default: mem_ready = ($urandom_range(0, 3) != 0);
        endcase
        for (int c = 0; c < NC; c++) begin
            ch_cmd_valid[c]          = req_pend[c] && rst_drv;
            ch_cmd_addr[c*AW +: AW]  = req_addr[c];
            ch_cmd_len[c*LW +: LW]   = LW'(req_len[c]);
            if (phase == 1 && c == g_ch) begin
                ch_data_valid[c]        = !dv_rand || ($urandom_range(0, 3) != 0);
                ch_data[c*DW +: DW]     = cur_beats[b_acc];
            end else begin
                ch_data_valid[c]        = noise_en && ($urandom_range(0, 1) == 1);
                ch_data[c*DW +: DW]     = rnd_data();
            end
        end
    endtask

    task automatic step();
        int occ, gnt, nphase, c;
        logic [NC-1:0] exp_cmd, exp_dr, exp_done;
        logic [AW-1:0] a;
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
            phase     = 0;
            rr_last   = NC - 1;
            last_head = '0;
            return;
        end
        occ = exp_q.size();
        gnt = -1;
        exp_cmd = '0;
        if (phase == 0) begin
            for (int k = 1; k <= NC; k++) begin
                c = (rr_last + k) % NC;
                if (gnt < 0 && ch_cmd_valid[c]) gnt = c;
            end
        end
        if (gnt >= 0) exp_cmd[gnt] = 1'b1;
        chk("cmd_ready", ch_cmd_ready, exp_cmd);
        exp_dr = '0;
        if (phase == 1 && occ < DEPTH) exp_dr[g_ch] = 1'b1;
        chk("data_ready", ch_data_ready, exp_dr);
        chk("write_en", write_en_out, occ != 0);
        chk("head", {address_out, dataOut}, (occ != 0) ? exp_q[0] : last_head);
        chk("busy", busy, phase != 0);
        nphase   = phase;
        exp_done = '0;
        if (phase == 2 && occ == 0) begin
            exp_done[g_ch] = 1'b1;
            done_cnt[g_ch]++;
            nphase = 0;
        end
        chk("done", done, exp_done);
        if (occ != 0 && mem_ready) last_head = exp_q.pop_front();
        if (phase == 1 && ch_data_valid[g_ch] && occ < DEPTH) begin
            a = b_addr + AW'(b_acc);
            exp_q.push_back({a, cur_beats[b_acc]});
            b_acc++;
            if (b_acc == b_len + 1) nphase = 2;
        end
        if (gnt >= 0) begin
            g_ch    = gnt;
            rr_last = gnt;
            b_addr  = req_addr[gnt];
            b_len   = req_len[gnt];
            b_acc   = 0;
            for (int i = 0; i < 16; i++) cur_beats[i] = req_beats[gnt][i];
            req_pend[gnt] = 1'b0;
            grant_log.push_back(gnt);
            nphase = 1;
        end
        phase = nphase;
    endtask

    task automatic cyc();
        drive();
        step();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int t;
        bit idle;
        t = 0;
        idle = model_idle();
        while (!idle && t < budget) begin
            cyc();
            t++;
            idle = model_idle();
        end
        chk(tag, idle, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cmd_ready"}, ch_cmd_ready, '0);
        chk({tag, "_data_ready"}, ch_data_ready, '0);
        chk({tag, "_write_en"}, write_en_out, 1'b0);
        chk({tag, "_address"}, address_out, '0);
        chk({tag, "_data"}, dataOut, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, '0);
    endtask

    initial begin
        int s, d0, t;
        rst = 1'b0; rst_drv = 1'b0;
        ch_cmd_valid = '0; ch_cmd_addr = '0; ch_cmd_len = '0;
        ch_data_valid = '0; ch_data = '0; mem_ready = 1'b0;
        mr_mode = 0; dv_rand = 1'b0; noise_en = 1'b0;
        phase = 0; rr_last = NC - 1; g_ch = 0; b_len = 0; b_acc = 0; b_addr = '0;
        last_head = '0;
        for (int c = 0; c < NC; c++) begin
            req_pend[c] = 1'b0; req_addr[c] = '0; req_len[c] = 0; done_cnt[c] = 0;
        end

        // Power-on reset
        for (int i = 0; i < 3; i++) cyc();
        chk_zero("reset");
        rst_drv = 1'b1;
        cyc();

        // Single burst with fixed beats
        submit(0, 12'h010, 3);
        req_beats[0][0] = 108'h115;
        req_beats[0][1] = 108'h117;
        req_beats[0][2] = 108'h120;
        req_beats[0][3] = 108'h121;
        run_until_idle(100, "single_idle");
        chk("single_done_cnt", done_cnt[0], 1);

        // Address wrap
        submit(0, 12'hFFE, 3);
        run_until_idle(100, "wrap_idle");

        // Backpressure: memory stalled while an 8-beat burst streams in
        mr_mode = 2;
        submit(1, AW'($urandom), 7);
        for (int i = 0; i < 12; i++) cyc();
        chk("bp_accepted", b_acc, DEPTH);
        mr_mode = 0;
        run_until_idle(200, "bp_idle");
        chk("bp_done_cnt", done_cnt[1], 1);

        // Arbitration with simultaneous requests, twice
        s = grant_log.size();
        submit(0, AW'($urandom), 1);
        submit(1, AW'($urandom), 2);
        run_until_idle(200, "arb1_idle");
        submit(0, AW'($urandom), 0);
        submit(1, AW'($urandom), 3);
        run_until_idle(200, "arb2_idle");
        chk("arb_g0", grant_log[s], 0);
        chk("arb_g1", grant_log[s+1], 1);
        chk("arb_g2", grant_log[s+2], 0);
        chk("arb_g3", grant_log[s+3], 1);

        // Reset after two beats of a four-beat burst
        d0 = done_cnt[0];
        submit(0, AW'($urandom), 3);
        t = 0;
        while (!(phase == 1 && b_acc == 2) && t < 50) begin
            cyc();
            t++;
        end
        chk("mid_reset_reached", b_acc, 2);
        rst_drv = 1'b0;
        cyc();
        cyc();
        chk_zero("mid_reset");
        rst_drv = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("mid_reset_no_done", done_cnt[0], d0);
        s = grant_log.size();
        submit(1, AW'($urandom), 2);
        run_until_idle(100, "post_reset_idle");
        chk("post_reset_grant", grant_log[s], 1);

        // Randomized traffic
        mr_mode = 1; dv_rand = 1'b1; noise_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (!req_pend[c] && $urandom_range(0, 7) == 0)
                    submit(c, AW'($urandom), int'($urandom_range(0, 15)));
            end
            cyc();
        end
        run_until_idle(3000, "random_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
